// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the stack-machine datapath
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   ir_1, ir_2, ir_3      opcode and register fields of the instruction register
//   zero                  ALU zero flag, sampled combinationally in BEQZ EXEC
//   irLoad, pcLoad        instruction register / PC load strobes
//   branch, muxreturn     PC source selects (branch target / memory data, else PC+1)
//   memEnable, memReadWrite, muxPP, muxpush   shared memory port control
//   aluOp, regLoad, wbSel ALU operation and register writeback control
//   spInc, spDec          stack pointer post-increment / pre-decrement
//   halted, state         HALT indication and debug state
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] ir_1,
   input  logic [1:0] ir_2,
   input  logic [1:0] ir_3,
   input  logic       zero,
   output logic       irLoad,
   output logic       pcLoad,
   output logic       branch,
   output logic       muxreturn,
   output logic       memEnable,
   output logic       memReadWrite,
   output logic [1:0] muxPP,
   output logic       muxpush,
   output logic [1:0] aluOp,
   output logic       regLoad,
   output logic       wbSel,
   output logic       spInc,
   output logic       spDec,
   output logic       halted,
   output logic [2:0] state
);
   localparam logic [2:0] S_FETCH = 3'b000, S_DECODE = 3'b001, S_EXEC = 3'b010,
                          S_MEM = 3'b011, S_WB = 3'b100, S_HALT = 3'b101;
   localparam logic [3:0] OP_NOP = 4'b1000, OP_LOAD = 4'b1001, OP_STORE = 4'b1010,
                          OP_BEQZ = 4'b1011, OP_PUSH = 4'b1100, OP_POP = 4'b1101,
                          OP_CALL = 4'b1110, OP_RET = 4'b1111;
   logic [2:0] next_state;
   logic [3:0] op;
   logic [1:0] op_r2, op_r3;
   // register fields are latched for the datapath's view of the instruction; sequencing never needs them
   logic unused_fields;
   assign unused_fields = ^{op_r2, op_r3};
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= S_FETCH;
         op    <= OP_NOP;
         op_r2 <= 2'b00;
         op_r3 <= 2'b00;
      end else begin
         state <= next_state;
         if (state == S_DECODE) begin
            op    <= ir_1;
            op_r2 <= ir_2;
            op_r3 <= ir_3;
         end
      end
   // DECODE looks at the live IR; later states only at the latched copy
   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH:  next_state = S_DECODE;
         S_DECODE: next_state = ~ir_1[3] ? S_EXEC :
                                (ir_1 == OP_POP || ir_1 == OP_RET) ? S_MEM :
                                (ir_1 == OP_NOP) ? (ir_2 == 2'b11 ? S_HALT : S_FETCH) : S_EXEC;
         S_EXEC:   next_state = ~op[3] ? S_WB :
                                (op == OP_LOAD || op == OP_STORE || op == OP_PUSH || op == OP_CALL) ? S_MEM : S_FETCH;
         S_MEM:    next_state = (op == OP_LOAD || op == OP_POP) ? S_WB : S_FETCH;
         S_WB:     next_state = S_FETCH;
         S_HALT:   next_state = S_HALT;
         default:  next_state = S_FETCH;
      endcase
   end
   // outputs are gated by reset itself so an asserted reset kills any in-flight access at once
   always_comb begin
      irLoad       = 1'b0;
      pcLoad       = 1'b0;
      branch       = 1'b0;
      muxreturn    = 1'b0;
      memEnable    = 1'b0;
      memReadWrite = 1'b0;
      muxPP        = 2'b00;
      muxpush      = 1'b0;
      aluOp        = 2'b00;
      regLoad      = 1'b0;
      wbSel        = 1'b0;
      spInc        = 1'b0;
      spDec        = 1'b0;
      halted       = 1'b0;
      if (!reset)
         case (state)
            S_FETCH: begin
               memEnable = 1'b1;
               irLoad    = 1'b1;
               pcLoad    = 1'b1;
            end
            S_EXEC: begin
               aluOp  = ~op[3] ? op[1:0] : (op == OP_BEQZ ? 2'b01 : 2'b00);
               branch = op == OP_BEQZ && zero;
               pcLoad = op == OP_BEQZ && zero;
               spDec  = op == OP_PUSH || op == OP_CALL;
            end
            S_MEM: begin
               memEnable    = 1'b1;
               memReadWrite = op == OP_STORE || op == OP_PUSH || op == OP_CALL;
               muxPP        = (op == OP_LOAD || op == OP_STORE) ? 2'b01 : 2'b10;
               muxpush      = op == OP_CALL;
               branch       = op == OP_CALL;
               muxreturn    = op == OP_RET;
               pcLoad       = op == OP_CALL || op == OP_RET;
               spInc        = op == OP_RET;
            end
            S_WB: begin
               regLoad = 1'b1;
               wbSel   = op[3];
               spInc   = op == OP_POP;
            end
            S_HALT:  halted = 1'b1;
            default: ;
         endcase
   end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed scoreboard bench for multicycle_controller
module tb_multicycle_controller;
   logic       clk = 1'b0, reset = 1'b1, zero = 1'b0;
   logic [3:0] ir_1 = 4'b0000;
   logic [1:0] ir_2 = 2'b00, ir_3 = 2'b00;
   logic       irLoad, pcLoad, branch, muxreturn, memEnable, memReadWrite, muxpush;
   logic       regLoad, wbSel, spInc, spDec, halted;
   logic [1:0] muxPP, aluOp;
   logic [2:0] state;
   int checks = 0, failures = 0;
   typedef struct {
      logic [18:0] vec;
      string       name;
   } exp_t;
   exp_t q[$];
   localparam logic [15:0] IRL = 16'h8000, PCL = 16'h4000, BR = 16'h2000, MR = 16'h1000,
                           ME = 16'h0800, WR = 16'h0400, PP_ALU = 16'h0100, PP_SP = 16'h0200,
                           PSH = 16'h0080, ALU_SUB = 16'h0020, ALU_OR = 16'h0060, RL = 16'h0010,
                           WB1 = 16'h0008, SPI = 16'h0004, SPD = 16'h0002, HLT = 16'h0001;
   localparam logic [15:0] F_FETCH = IRL | PCL | ME;
   multicycle_controller dut (
      .clk(clk), .reset(reset), .ir_1(ir_1), .ir_2(ir_2), .ir_3(ir_3), .zero(zero),
      .irLoad(irLoad), .pcLoad(pcLoad), .branch(branch), .muxreturn(muxreturn),
      .memEnable(memEnable), .memReadWrite(memReadWrite), .muxPP(muxPP), .muxpush(muxpush),
      .aluOp(aluOp), .regLoad(regLoad), .wbSel(wbSel), .spInc(spInc), .spDec(spDec),
      .halted(halted), .state(state)
   );
   always #5 clk = ~clk;
   // monitor: one expected vector per cycle, compared mid-cycle
   always @(negedge clk)
      if (q.size() > 0) begin
         exp_t e;
         logic [18:0] got;
         e = q.pop_front();
         got = {state, irLoad, pcLoad, branch, muxreturn, memEnable, memReadWrite, muxPP,
                muxpush, aluOp, regLoad, wbSel, spInc, spDec, halted};
         checks++;
         if (got !== e.vec) begin
            failures++;
            $display("FAIL %s: got state=%b flags=%h, expected state=%b flags=%h",
                     e.name, got[18:16], got[15:0], e.vec[18:16], e.vec[15:0]);
         end
      end
   // queue the expectation for the coming cycle, then advance one clock
   task automatic step(input string name, input logic [2:0] s, input logic [15:0] f);
      exp_t e;
      e.vec = {s, f};
      e.name = name;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask
   task automatic set_ir(input logic [3:0] a, input logic [1:0] b, input logic [1:0] c);
      ir_1 = a;
      ir_2 = b;
      ir_3 = c;
   endtask
   initial begin
      @(posedge clk);
      #1;
      step("rst_hold0", 3'b000, 16'h0);
      step("rst_hold1", 3'b000, 16'h0);
      set_ir(4'b0111, 2'b10, 2'b01);
      reset = 1'b0;
      step("alu_fetch", 3'b000, F_FETCH);
      step("alu_decode", 3'b001, 16'h0);
      ir_1 = 4'b1111;
      step("alu_exec", 3'b010, ALU_OR);
      step("alu_wb", 3'b100, RL);
      set_ir(4'b1001, 2'b01, 2'b10);
      step("load_fetch", 3'b000, F_FETCH);
      step("load_decode", 3'b001, 16'h0);
      step("load_exec", 3'b010, 16'h0);
      step("load_mem", 3'b011, ME | PP_ALU);
      step("load_wb", 3'b100, RL | WB1);
      set_ir(4'b1010, 2'b11, 2'b00);
      step("store_fetch", 3'b000, F_FETCH);
      step("store_decode", 3'b001, 16'h0);
      step("store_exec", 3'b010, 16'h0);
      step("store_mem", 3'b011, ME | WR | PP_ALU);
      set_ir(4'b1011, 2'b00, 2'b01);
      zero = 1'b1;
      step("beqz1_fetch", 3'b000, F_FETCH);
      step("beqz1_decode", 3'b001, 16'h0);
      step("beqz1_exec", 3'b010, ALU_SUB | BR | PCL);
      zero = 1'b0;
      step("beqz0_fetch", 3'b000, F_FETCH);
      step("beqz0_decode", 3'b001, 16'h0);
      step("beqz0_exec", 3'b010, ALU_SUB);
      set_ir(4'b1100, 2'b10, 2'b00);
      step("push_fetch", 3'b000, F_FETCH);
      step("push_decode", 3'b001, 16'h0);
      step("push_exec", 3'b010, SPD);
      step("push_mem", 3'b011, ME | WR | PP_SP);
      set_ir(4'b1101, 2'b01, 2'b00);
      step("pop_fetch", 3'b000, F_FETCH);
      step("pop_decode", 3'b001, 16'h0);
      step("pop_mem", 3'b011, ME | PP_SP);
      step("pop_wb", 3'b100, RL | WB1 | SPI);
      set_ir(4'b1110, 2'b00, 2'b00);
      step("call_fetch", 3'b000, F_FETCH);
      step("call_decode", 3'b001, 16'h0);
      step("call_exec", 3'b010, SPD);
      step("call_mem", 3'b011, ME | WR | PP_SP | PSH | BR | PCL);
      set_ir(4'b1111, 2'b00, 2'b00);
      step("ret_fetch", 3'b000, F_FETCH);
      step("ret_decode", 3'b001, 16'h0);
      step("ret_mem", 3'b011, ME | PP_SP | MR | PCL | SPI);
      set_ir(4'b1000, 2'b01, 2'b00);
      step("nop_fetch", 3'b000, F_FETCH);
      step("nop_decode", 3'b001, 16'h0);
      set_ir(4'b1001, 2'b10, 2'b00);
      step("ldrst_fetch", 3'b000, F_FETCH);
      step("ldrst_decode", 3'b001, 16'h0);
      step("ldrst_exec", 3'b010, 16'h0);
      reset = 1'b1;
      step("ldrst_in_mem", 3'b000, 16'h0);
      step("ldrst_hold", 3'b000, 16'h0);
      reset = 1'b0;
      set_ir(4'b1000, 2'b11, 2'b00);
      step("halt_fetch", 3'b000, F_FETCH);
      step("halt_decode", 3'b001, 16'h0);
      set_ir(4'b0111, 2'b10, 2'b00);
      for (int i = 0; i < 10; i++) step($sformatf("halt_hold%0d", i), 3'b101, HLT);
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
